// File: rtl/serial_adder_pkg.sv
// Shared definitions for the multi-channel bit-serial adder/subtractor.
//   state_t     : controller states (IDLE, RUN, DONE)
//   cnt_width() : bit counter width, max(1, clog2(WIDTH))
//   lane_lo()   : low bit of channel i in a packed NCH*WIDTH vector
//   DEF_*       : default geometry
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NCH   = 2;

  function automatic int unsigned cnt_width(input int unsigned w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  // Channel i occupies bits [i*w +: w]; channel 0 sits at the LSBs.
  function automatic int unsigned lane_lo(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/serial_fa_lane.sv
// One channel of the bit-serial adder: operand shift registers, carry
// register and result shift register.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : load operands (B inverted when i_sub) and seed carry
//   i_shift   : perform one full-adder bit step, LSB first
//   i_sub     : subtract mode for the load
//   i_a, i_b  : operands
//   o_sum     : result shift register
//   o_cout    : carry register (1 = no borrow in subtract mode)
module serial_fa_lane
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_s = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

  // Built via shift-then-overwrite so WIDTH = 1 needs no special case.
  always_comb begin
    w_res_nxt            = r_res >> 1;
    w_res_nxt[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
    end else if (i_load) begin
      r_a <= i_a;
      r_b <= i_sub ? ~i_b : i_b;
      r_c <= i_sub;
    end else if (i_shift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_c;
      r_res <= w_res_nxt;
    end
  end

  assign o_sum  = r_res;
  assign o_cout = r_c;

endmodule

// File: rtl/serial_adder_array.sv
// NCH-channel bit-serial adder/subtractor with valid/ready on both sides.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (accepted only in IDLE)
//   op_sub, ch_en     : mode and channel enables, sampled at accept
//   a, b              : packed operands, channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready : result handshake
//   sum, cout         : packed results and per-channel carry, disabled
//                       channels read 0; last result held after consume
module serial_adder_array
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH*WIDTH-1:0] a,
  input  logic [NCH*WIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] sum,
  output logic [NCH-1:0]       cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [NCH-1:0]       r_en;
  logic [NCH*WIDTH-1:0] r_sum;
  logic [NCH-1:0]       r_cout;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_last;
  logic [NCH*WIDTH-1:0] w_lane_sum;
  logic [NCH-1:0]       w_lane_cout;
  logic [NCH*WIDTH-1:0] w_live_sum;
  logic [NCH-1:0]       w_live_cout;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_shift = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_en    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt <= '0;
        r_en  <= ch_en;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    serial_fa_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_sub   (op_sub),
      .i_a     (a[lane_lo(i, WIDTH) +: WIDTH]),
      .i_b     (b[lane_lo(i, WIDTH) +: WIDTH]),
      .o_sum   (w_lane_sum[lane_lo(i, WIDTH) +: WIDTH]),
      .o_cout  (w_lane_cout[i])
    );
    assign w_live_sum[lane_lo(i, WIDTH) +: WIDTH] =
      w_lane_sum[lane_lo(i, WIDTH) +: WIDTH] & {WIDTH{r_en[i]}};
    assign w_live_cout[i] = w_lane_cout[i] & r_en[i];
  end

  // Lanes are frozen in DONE, so their registers drive the outputs directly
  // there; the hold copy taken during DONE covers IDLE/RUN so the next
  // transaction's partial bits never leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= '0;
    end else if (r_state == DONE) begin
      r_sum  <= w_live_sum;
      r_cout <= w_live_cout;
    end
  end

  assign sum  = (r_state == DONE) ? w_live_sum  : r_sum;
  assign cout = (r_state == DONE) ? w_live_cout : r_cout;

endmodule

// File: tb/tb_serial_adder_array.sv
module tb_serial_adder_array;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [1:0]  ch_en;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic [1:0]  cout;

  logic        w1_in_valid;
  logic        w1_in_ready;
  logic        w1_op_sub;
  logic [2:0]  w1_ch_en;
  logic [2:0]  w1_a;
  logic [2:0]  w1_b;
  logic        w1_out_valid;
  logic        w1_out_ready;
  logic [2:0]  w1_sum;
  logic [2:0]  w1_cout;

  int total;
  int bad;

  serial_adder_array #(.WIDTH(8), .NCH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .ch_en(ch_en), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  serial_adder_array #(.WIDTH(1), .NCH(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .op_sub(w1_op_sub), .ch_en(w1_ch_en), .a(w1_a), .b(w1_b),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .sum(w1_sum), .cout(w1_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [1:0]  en;
    logic [15:0] exp_sum;
    logic [1:0]  exp_cout;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand word, wait for the accept edge, then count edges
  // until out_valid (bounded). Leaves the DUT in DONE.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic sub,
                       input logic [1:0] en, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; op_sub = sub; ch_en = en; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] held_sum;
    logic [1:0]  held_cout;

    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; ch_en = '0; a = '0; b = '0; out_ready = 1'b0;
    w1_in_valid = 1'b0; w1_op_sub = 1'b0; w1_ch_en = '0; w1_a = '0; w1_b = '0; w1_out_ready = 1'b0;

    vecs[0] = '{16'hFF0F, 16'h0101, 1'b0, 2'b11, 16'h0010, 2'b10};
    vecs[1] = '{16'h0705, 16'h0507, 1'b1, 2'b11, 16'h02FE, 2'b10};
    vecs[2] = '{16'h803C, 16'h80C3, 1'b0, 2'b11, 16'h00FF, 2'b10};
    vecs[3] = '{16'hAA10, 16'hAA01, 1'b1, 2'b11, 16'h000F, 2'b11};
    vecs[4] = '{16'hFF12, 16'hFF34, 1'b0, 2'b01, 16'h0046, 2'b00};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {16'd0, sum},       32'd0);
    check("rst_cout",      {30'd0, cout},      32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_sum",       {16'd0, sum},       32'd0);

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].en, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd8);
      check($sformatf("vec%0d_sum", i),  {16'd0, sum},  {16'd0, vecs[i].exp_sum});
      check($sformatf("vec%0d_cout", i), {30'd0, cout}, {30'd0, vecs[i].exp_cout});
      consume();
      check($sformatf("vec%0d_idle_after", i), {30'd0, in_ready, out_valid}, 32'd2);
      check($sformatf("vec%0d_sum_kept", i), {16'd0, sum}, {16'd0, vecs[i].exp_sum});
    end

    // Backpressure: result held, new operands ignored while not consumed.
    issue(16'h0102, 16'h0304, 1'b0, 2'b11, lat);
    check("bp_latency", lat, 32'd8);
    held_sum = sum; held_cout = cout;
    check("bp_sum", {16'd0, held_sum}, 32'h0406);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b1; ch_en = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_sum",   {16'd0, sum},  {16'd0, held_sum});
      check("bp_hold_cout",  {30'd0, cout}, {30'd0, held_cout});
      check("bp_in_ready",   {31'd0, in_ready},  32'd0);
      check("bp_out_valid",  {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    consume();
    check("bp_released", {30'd0, in_ready, out_valid}, 32'd2);
    check("bp_sum_kept", {16'd0, sum}, {16'd0, held_sum});

    // Reset three edges after accept discards the transaction.
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; op_sub = 1'b0; ch_en = 2'b11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("run_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum",       {16'd0, sum},       32'd0);
    check("midrst_cout",      {30'd0, cout},      32'd0);
    issue(16'h0012, 16'h0034, 1'b0, 2'b11, lat);
    check("post_rst_latency", lat, 32'd8);
    check("post_rst_sum",  {16'd0, sum},  32'h0046);
    check("post_rst_cout", {30'd0, cout}, 32'd0);
    consume();

    // WIDTH = 1, NCH = 3.
    @(negedge clk);
    check("w1_in_ready", {31'd0, w1_in_ready}, 32'd1);
    w1_a = 3'b111; w1_b = 3'b101; w1_op_sub = 1'b0; w1_ch_en = 3'b111; w1_in_valid = 1'b1;
    @(posedge clk);
    #1 w1_in_valid = 1'b0;
    check("w1_not_yet_valid", {31'd0, w1_out_valid}, 32'd0);
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      if (w1_out_valid) break;
    end
    check("w1_latency", lat, 32'd1);
    check("w1_sum",  {29'd0, w1_sum},  32'd2);
    check("w1_cout", {29'd0, w1_cout}, 32'd5);
    @(negedge clk);
    w1_out_ready = 1'b1;
    @(posedge clk);
    #1 w1_out_ready = 1'b0;
    check("w1_idle_after", {30'd0, w1_in_ready, w1_out_valid}, 32'd2);
    check("w1_sum_kept", {29'd0, w1_sum}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
